multiport_ram_arb: RTL and testbench

//  Parametrised PORTS-port synchronous word RAM, generalising our fixed Left/Right/Middle cell matrix.

---
 rtl/multiport_ram_arb.sv | 101 ++++++++++
 tb/tb_multiport_ram_arb.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/multiport_ram_arb.sv
// multiport_ram_arb: PORTS-port synchronous word RAM with write-collision arbitration and post-reset self-clear.
// Ports: clk, reset (sync, active-high); per port p, slice p of en/we/addr/wdata selects an access;
// rdata/rvalid return the registered read one cycle later; wr_lost pulses for a write that lost arbitration;
// ready is high once the whole array has been zeroed after reset.
module multiport_ram_arb #(
  parameter int N = 32,
  parameter int no_addr_lines = 5,
  parameter int wordsize = 16,
  parameter int PORTS = 3,
  parameter int RD_MODE = 0,
  parameter int ARB_MODE = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [PORTS-1:0]                   en,
  input  logic [PORTS-1:0]                   we,
  input  logic [PORTS*no_addr_lines-1:0]     addr,
  input  logic [PORTS*wordsize-1:0]          wdata,
  output logic [PORTS*wordsize-1:0]          rdata,
  output logic [PORTS-1:0]                   rvalid,
  output logic [PORTS-1:0]                   wr_lost,
  output logic                               ready
);
  localparam int AW = no_addr_lines;
  localparam int W = wordsize;
  localparam int PW = $clog2(PORTS);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [W-1:0] mem [N];
  logic [AW-1:0] clr_ptr;
  logic [PW-1:0] rr_ptr, rr_n;
  logic [AW-1:0] a [PORTS];
  logic [W-1:0] d [PORTS];
  logic [W-1:0] rd [PORTS];
  logic [PORTS-1:0] wv, win, coll, lost, rd_en;
  // Arbitration rank: smaller wins; round-robin measures distance from rr_ptr.
  function automatic int pri(int q, logic [PW-1:0] rr);
    return (ARB_MODE != 0) ? (q + PORTS - int'(rr)) % PORTS : q;
  endfunction
  always_comb begin
    state_n = (state == CLEAR && clr_ptr == LAST) ? RUN : state;
  end
  assign ready = state == RUN;
  always_comb begin
    wv = '0;
    rd_en = '0;
    win = '0;
    coll = '0;
    rr_n = rr_ptr;
    for (int p = 0; p < PORTS; p++) begin
      a[p] = addr[p*AW +: AW];
      d[p] = wdata[p*W +: W];
      wv[p] = ready && en[p] && we[p] && (32'(a[p]) < N);
      rd_en[p] = ready && en[p] && !we[p];
    end
    for (int p = 0; p < PORTS; p++) begin
      win[p] = wv[p];
      for (int q = 0; q < PORTS; q++)
        if (q != p && wv[p] && wv[q] && a[q] == a[p]) begin
          coll[p] = 1'b1;
          if (pri(q, rr_ptr) < pri(p, rr_ptr)) win[p] = 1'b0;
        end
    end
    lost = wv & ~win;
    // Highest-indexed collision winner sets the next round-robin start.
    for (int p = 0; p < PORTS; p++)
      if (win[p] && coll[p]) rr_n = PW'((p + 1) % PORTS);
    for (int p = 0; p < PORTS; p++) begin
      rd[p] = (32'(a[p]) < N) ? mem[a[p]] : '0;
      if (RD_MODE != 0)
        for (int q = 0; q < PORTS; q++)
          if (win[q] && a[q] == a[p]) rd[p] = d[q];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      clr_ptr <= '0;
      rr_ptr <= '0;
      rdata <= '0;
      rvalid <= '0;
      wr_lost <= '0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_n;
      rvalid <= rd_en;
      wr_lost <= lost;
      if (!ready) clr_ptr <= clr_ptr + 1'b1;
      for (int p = 0; p < PORTS; p++)
        if (rd_en[p]) rdata[p*W +: W] <= rd[p];
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!ready) mem[clr_ptr] <= '0;
      for (int p = 0; p < PORTS; p++)
        if (win[p]) mem[a[p]] <= d[p];
    end
  end
endmodule

// File: tb/tb_multiport_ram_arb.sv
// tb_multiport_ram_arb: self-checking bench for multiport_ram_arb (fixed/round-robin, old/new read, short array).
module tb_multiport_ram_arb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] en = '0, we = '0;
  logic [14:0] addr = '0;
  logic [47:0] wdata = '0;
  logic [47:0] rd_a, rd_b, rd_c;
  logic [2:0] rv_a, rv_b, rv_c, lost_a, lost_b, lost_c;
  logic ready_a, ready_b, ready_c;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  multiport_ram_arb dut_a (.clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rd_a), .rvalid(rv_a), .wr_lost(lost_a), .ready(ready_a));
  multiport_ram_arb #(.RD_MODE(1), .ARB_MODE(1)) dut_b (.clk(clk), .reset(reset), .en(en), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rd_b), .rvalid(rv_b), .wr_lost(lost_b), .ready(ready_b));
  multiport_ram_arb #(.N(24)) dut_c (.clk(clk), .reset(reset), .en(en), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rd_c), .rvalid(rv_c), .wr_lost(lost_c), .ready(ready_c));
  typedef struct {
    logic [2:0] en, we;
    logic [14:0] addr;
    logic [47:0] wdata;
    logic [2:0] rv, la, lb;
    logic [47:0] ra, rb;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic apply(vec_t v);
    vec_t e;
    logic [47:0] m;
    en = v.en;
    we = v.we;
    addr = v.addr;
    wdata = v.wdata;
    sb.push_back(v);
    tick();
    e = sb.pop_front();
    m = {{16{e.rv[2]}}, {16{e.rv[1]}}, {16{e.rv[0]}}};
    chk("rvalid_a", 48'(rv_a), 48'(e.rv));
    chk("rvalid_b", 48'(rv_b), 48'(e.rv));
    chk("wr_lost_a", 48'(lost_a), 48'(e.la));
    chk("wr_lost_b", 48'(lost_b), 48'(e.lb));
    if (e.rv != 3'b000) begin
      chk("rdata_a", rd_a & m, e.ra & m);
      chk("rdata_b", rd_b & m, e.rb & m);
    end
  endtask
  task automatic wait_ready(int exp_a, int exp_c);
    int got_a = -1;
    int got_c = -1;
    for (int i = 1; i <= 40 && got_a < 0; i++) begin
      tick();
      if (ready_a && got_a < 0) got_a = i;
      if (ready_c && got_c < 0) got_c = i;
    end
    chk("ready_edge_a", 48'(got_a), 48'(exp_a));
    chk("ready_edge_c", 48'(got_c), 48'(exp_c));
  endtask
  initial begin
    logic bad;
    tick();
    chk("reset_ready", 48'({ready_a, ready_b, ready_c}), 48'(0));
    chk("reset_rvalid", 48'({rv_a, rv_b}), 48'(0));
    chk("reset_lost", 48'({lost_a, lost_b}), 48'(0));
    chk("reset_rdata", rd_a | rd_b, 48'h0);
    reset = 1'b0;
    en = 3'b111;
    we = 3'b001;
    wdata = 48'h0000_0000_FFFF;
    bad = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (rv_a != 0 || rv_b != 0 || lost_a != 0 || lost_b != 0 || ready_a) bad = 1'b1;
    end
    chk("clear_quiet", 48'(bad), 48'(0));
    tick();
    chk("ready_at_32", 48'({ready_a, ready_b}), 48'(3));
    en = '0;
    we = '0;
    for (int i = 0; i < 32; i++)
      apply(vec_t'{3'b011, 3'b000, {5'd0, 5'(31 - i), 5'(i)}, 48'h0, 3'b011, 3'b000, 3'b000, 48'h0, 48'h0});
    tbl.push_back(vec_t'{3'b111, 3'b111, {5'd2, 5'd1, 5'd0}, {16'h00FF, 16'h000F, 16'h0000},
      3'b000, 3'b000, 3'b000, 48'h0, 48'h0});
    tbl.push_back(vec_t'{3'b111, 3'b000, {5'd2, 5'd1, 5'd0}, 48'h0, 3'b111, 3'b000, 3'b000,
      {16'h00FF, 16'h000F, 16'h0000}, {16'h00FF, 16'h000F, 16'h0000}});
    tbl.push_back(vec_t'{3'b111, 3'b111, {5'd7, 5'd7, 5'd7}, {16'hA02, 16'hA01, 16'hA00},
      3'b000, 3'b110, 3'b110, 48'h0, 48'h0});
    tbl.push_back(vec_t'{3'b111, 3'b111, {5'd7, 5'd7, 5'd7}, {16'hA02, 16'hA01, 16'hA00},
      3'b000, 3'b110, 3'b101, 48'h0, 48'h0});
    tbl.push_back(vec_t'{3'b111, 3'b111, {5'd7, 5'd7, 5'd7}, {16'hA02, 16'hA01, 16'hA00},
      3'b000, 3'b110, 3'b011, 48'h0, 48'h0});
    tbl.push_back(vec_t'{3'b111, 3'b000, {5'd7, 5'd7, 5'd7}, 48'h0, 3'b111, 3'b000, 3'b000,
      {16'hA00, 16'hA00, 16'hA00}, {16'hA02, 16'hA02, 16'hA02}});
    tbl.push_back(vec_t'{3'b101, 3'b101, {5'd5, 5'd0, 5'd5}, {16'h2222, 16'h0, 16'h1111},
      3'b000, 3'b100, 3'b100, 48'h0, 48'h0});
    tbl.push_back(vec_t'{3'b010, 3'b000, {5'd0, 5'd5, 5'd0}, 48'h0, 3'b010, 3'b000, 3'b000,
      {16'h0, 16'h1111, 16'h0}, {16'h0, 16'h1111, 16'h0}});
    tbl.push_back(vec_t'{3'b001, 3'b001, {5'd0, 5'd0, 5'd9}, {16'h0, 16'h0, 16'hBEEF},
      3'b000, 3'b000, 3'b000, 48'h0, 48'h0});
    tbl.push_back(vec_t'{3'b011, 3'b001, {5'd0, 5'd9, 5'd9}, {16'h0, 16'h0, 16'hCAFE},
      3'b010, 3'b000, 3'b000, {16'h0, 16'hBEEF, 16'h0}, {16'h0, 16'hCAFE, 16'h0}});
    tbl.push_back(vec_t'{3'b100, 3'b000, {5'd9, 5'd0, 5'd0}, 48'h0, 3'b100, 3'b000, 3'b000,
      {16'hCAFE, 16'h0, 16'h0}, {16'hCAFE, 16'h0, 16'h0}});
    foreach (tbl[i]) apply(tbl[i]);
    en = '0;
    we = '0;
    tick();
    chk("idle_rvalid", 48'({rv_a, rv_b}), 48'(0));
    chk("hold_rdata", 48'(rd_a[47:32]), 48'hCAFE);
    en = 3'b001;
    we = 3'b001;
    addr = 15'd30;
    wdata = 48'h5555;
    tick();
    chk("oor_wr_lost", 48'(lost_c), 48'(0));
    we = 3'b000;
    tick();
    chk("oor_rvalid", 48'(rv_c), 48'(1));
    chk("oor_rdata", 48'(rd_c[15:0]), 48'h0);
    apply(vec_t'{3'b001, 3'b001, 15'd3, 48'h1234, 3'b000, 3'b000, 3'b000, 48'h0, 48'h0});
    apply(vec_t'{3'b001, 3'b000, 15'd3, 48'h0, 3'b001, 3'b000, 3'b000, 48'h1234, 48'h1234});
    en = '0;
    reset = 1'b1;
    tick();
    chk("run_reset_ready", 48'({ready_a, ready_b}), 48'(0));
    chk("run_reset_rvalid", 48'({rv_a, rv_b}), 48'(0));
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_clear_ready", 48'(ready_a), 48'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready(32, 24);
    apply(vec_t'{3'b111, 3'b000, {5'd3, 5'd3, 5'd3}, 48'h0, 3'b111, 3'b000, 3'b000, 48'h0, 48'h0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
